// File: rtl/sfx_pkg.sv
// Purpose : shared constants, FSM state type and per-effect tables for the sound-effect scheduler.
// Latency : n/a (package only).
// Backpressure : n/a; tables are indexed by the 2-bit effect id (0 = lowest priority).
package sfx_pkg;

  localparam int SFX_NUM_REQ  = 4;
  localparam int SFX_FRAME_W  = 6;
  localparam int SFX_PERIOD_W = 9;
  localparam int SFX_ID_W     = 2;

  localparam logic [SFX_ID_W-1:0] SFX_SHEEP   = 2'd0;
  localparam logic [SFX_ID_W-1:0] SFX_SWORD   = 2'd1;
  localparam logic [SFX_ID_W-1:0] SFX_SEGMENT = 2'd2;
  localparam logic [SFX_ID_W-1:0] SFX_PLAYER  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } sfx_state_e;

  // Effect length in frames; all entries stay <= 32 so the envelope never wraps.
  function automatic logic [SFX_FRAME_W-1:0] sfx_len(input logic [SFX_ID_W-1:0] id);
    case (id)
      SFX_SHEEP:   return 6'd16;
      SFX_SWORD:   return 6'd8;
      SFX_SEGMENT: return 6'd24;
      default:     return 6'd32;
    endcase
  endfunction

  function automatic logic sfx_noise_sel(input logic [SFX_ID_W-1:0] id);
    case (id)
      SFX_SWORD, SFX_PLAYER: return 1'b1;
      default:               return 1'b0;
    endcase
  endfunction

  function automatic logic [SFX_PERIOD_W-1:0] sfx_base(input logic [SFX_ID_W-1:0] id);
    case (id)
      SFX_SHEEP:   return 9'd120;
      SFX_SEGMENT: return 9'd64;
      default:     return 9'd0;
    endcase
  endfunction

  function automatic logic sfx_sweep(input logic [SFX_ID_W-1:0] id);
    return (id == SFX_SHEEP);
  endfunction

endpackage

// File: rtl/sfx_req_latch.sv
// Purpose : edge-detects request levels, holds one pending flag per source, flags repeats, encodes top priority.
// Latency : pending/top valid 1 clk after a req rise; dropped pulses 1 clk after the repeated rise.
// Backpressure : none; a rise on an already-pending source is discarded and reported on dropped_o.
// Ports : req_i (levels), clr_i (one-hot clear from the scheduler), pending_o, top_vld_o/top_idx_o, dropped_o.
module sfx_req_latch
  import sfx_pkg::*;
#(
  parameter int N  = SFX_NUM_REQ,
  parameter int IW = SFX_ID_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  clr_i,
  output logic [N-1:0]  pending_o,
  output logic          top_vld_o,
  output logic [IW-1:0] top_idx_o,
  output logic          dropped_o
);

  logic [N-1:0] req_q;
  logic [N-1:0] pend_q;
  logic [N-1:0] pend_d;
  logic [N-1:0] rise;
  logic         drop_q;

  assign rise   = req_i & ~req_q;
  // A new rise overrides a same-cycle clear so the request is never lost.
  assign pend_d = (pend_q & ~clr_i) | rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q  <= '0;
      pend_q <= '0;
      drop_q <= 1'b0;
    end else begin
      req_q  <= req_i;
      pend_q <= pend_d;
      drop_q <= |(rise & pend_q);
    end
  end

  // Highest set index wins: later loop iterations overwrite earlier ones.
  always_comb begin
    top_vld_o = 1'b0;
    top_idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (pend_q[i]) begin
        top_vld_o = 1'b1;
        top_idx_o = IW'(i);
      end
    end
  end

  assign pending_o = pend_q;
  assign dropped_o = drop_q;

endmodule

// File: rtl/sfx_scheduler.sv
// Purpose : arbitrates one-shot sound-effect requests and sequences the single effect voice per video frame.
// Latency : grant 1 clk after req rise, sfx_active 2 clk after; voice fields follow id/frame registers directly.
// Backpressure : lower/equal priority requests wait as pending; higher priority preempts during PLAY only.
// Ports : clk, rst_n, frame_tick, req, bgm_enable in; grant, dropped, sfx_active, sfx_id, sfx_noise,
//         sfx_period, envelope, bgm_mute out.
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int NUM_REQ  = SFX_NUM_REQ,
  parameter int FRAME_W  = SFX_FRAME_W,
  parameter int PERIOD_W = SFX_PERIOD_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_tick,
  input  logic [NUM_REQ-1:0]  req,
  input  logic                bgm_enable,
  output logic [NUM_REQ-1:0]  grant,
  output logic                dropped,
  output logic                sfx_active,
  output logic [1:0]          sfx_id,
  output logic                sfx_noise,
  output logic [PERIOD_W-1:0] sfx_period,
  output logic [4:0]          envelope,
  output logic                bgm_mute
);

  sfx_state_e            state_q, state_d;
  logic [SFX_ID_W-1:0]   id_q, id_d;
  logic [FRAME_W-1:0]    frame_q, frame_d;
  logic [NUM_REQ-1:0]    clr;
  logic [NUM_REQ-1:0]    pending;
  logic                  top_vld;
  logic [SFX_ID_W-1:0]   top_idx;
  logic                  take;
  logic [PERIOD_W+1:0]   period_sum;

  sfx_req_latch #(
    .N  (NUM_REQ),
    .IW (SFX_ID_W)
  ) u_req_latch (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req),
    .clr_i     (clr),
    .pending_o (pending),
    .top_vld_o (top_vld),
    .top_idx_o (top_idx),
    .dropped_o (dropped)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      frame_q <= frame_d;
    end
  end

  // Start (or restart) on the top pending source: from IDLE on anything, from PLAY only
  // when strictly higher than the sounding effect. GAP never starts an effect.
  always_comb begin
    take = 1'b0;
    if (top_vld) begin
      if (state_q == ST_IDLE) take = 1'b1;
      else if (state_q == ST_PLAY && top_idx > id_q) take = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    frame_d = frame_q;
    clr     = '0;
    grant   = '0;
    if (take) begin
      clr[top_idx]   = 1'b1;
      grant[top_idx] = 1'b1;
      id_d           = top_idx;
      frame_d        = '0;
      state_d        = ST_PLAY;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (frame_tick) begin
            if (frame_q == (sfx_len(id_q) - FRAME_W'(1))) state_d = ST_GAP;
            else                                            frame_d = frame_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (frame_tick) state_d = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  assign sfx_active = (state_q == ST_PLAY);

  // Sweep adds 4 per frame; the sum carries two spare bits so saturation can be detected.
  always_comb begin
    period_sum = (PERIOD_W+2)'(sfx_base(id_q));
    if (sfx_sweep(id_q)) period_sum = period_sum + (PERIOD_W+2)'({frame_q, 2'b00});
  end

  always_comb begin
    sfx_id     = '0;
    sfx_noise  = 1'b0;
    sfx_period = '0;
    envelope   = '0;
    if (sfx_active) begin
      sfx_id     = id_q;
      sfx_noise  = sfx_noise_sel(id_q);
      envelope   = 5'd31 - frame_q[4:0];
      if (period_sum > (PERIOD_W+2)'({PERIOD_W{1'b1}})) sfx_period = '1;
      else                                              sfx_period = period_sum[PERIOD_W-1:0];
    end
  end

  assign bgm_mute = sfx_active | ~bgm_enable;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Purpose : self-checking bench for sfx_scheduler: directed scenarios plus randomized traffic against a model.
// Latency : n/a (testbench).
// Backpressure : n/a; inputs driven on the falling edge, outputs sampled 1 time unit after the rising edge.
module tb_sfx_scheduler;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic [3:0] req;
  logic       bgm_enable;
  logic [3:0] grant;
  logic       dropped;
  logic       sfx_active;
  logic [1:0] sfx_id;
  logic       sfx_noise;
  logic [8:0] sfx_period;
  logic [4:0] envelope;
  logic       bgm_mute;

  sfx_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .req        (req),
    .bgm_enable (bgm_enable),
    .grant      (grant),
    .dropped    (dropped),
    .sfx_active (sfx_active),
    .sfx_id     (sfx_id),
    .sfx_noise  (sfx_noise),
    .sfx_period (sfx_period),
    .envelope   (envelope),
    .bgm_mute   (bgm_mute)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Effect tables written out from the effect descriptions.
  int T_LEN   [4] = '{16, 8, 24, 32};
  int T_NOISE [4] = '{0, 1, 0, 1};
  int T_BASE  [4] = '{120, 0, 64, 0};
  int T_SWEEP [4] = '{1, 0, 0, 0};

  // Behavioural model: set of waiting requests, the sounding effect (or none), and a silent-gap flag.
  bit   m_pend [4];
  bit   m_prev [4];
  int   m_id;       // -1 when no effect sounds
  int   m_frame;
  bit   m_gap;
  bit   m_drop;

  int   g_log[$];
  int   drop_cnt;
  int   act_cnt;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = 1'b0;
      m_prev[i] = 1'b0;
    end
    m_id = -1; m_frame = 0; m_gap = 1'b0; m_drop = 1'b0;
  endfunction

  function automatic int model_top();
    int t = -1;
    for (int i = 0; i < 4; i++) if (m_pend[i]) t = i;
    return t;
  endfunction

  // Which source is accepted right now: idle takes anything, playing takes only a higher one.
  function automatic int model_sel();
    int t = model_top();
    if (t < 0 || m_gap) return -1;
    if (m_id < 0) return t;
    if (t > m_id) return t;
    return -1;
  endfunction

  function automatic logic [3:0] model_grant();
    int s = model_sel();
    logic [3:0] g = 4'd0;
    if (s >= 0) g[s] = 1'b1;
    return g;
  endfunction

  function automatic int model_period();
    int p;
    if (m_id < 0) return 0;
    p = T_BASE[m_id] + (T_SWEEP[m_id] != 0 ? m_frame * 4 : 0);
    return (p > 511) ? 511 : p;
  endfunction

  function automatic void model_edge(input logic [3:0] r, input logic ft);
    int  s = model_sel();
    bit  d = 1'b0;
    bit  rise [4];
    for (int i = 0; i < 4; i++) begin
      rise[i] = r[i] && !m_prev[i];
      if (rise[i] && m_pend[i]) d = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      if (i == s) m_pend[i] = 1'b0;
      if (rise[i]) m_pend[i] = 1'b1;
      m_prev[i] = r[i];
    end
    if (s >= 0) begin
      m_id = s; m_frame = 0;
    end else if (m_id >= 0 && ft) begin
      if (m_frame + 1 == T_LEN[m_id]) begin
        m_id = -1; m_gap = 1'b1;
      end else begin
        m_frame = m_frame + 1;
      end
    end else if (m_gap && ft) begin
      m_gap = 1'b0;
    end
    m_drop = d;
  endfunction

  task automatic tick(input logic [3:0] r, input logic ft);
    @(negedge clk);
    req = r;
    frame_tick = ft;
    @(posedge clk);
    model_edge(r, ft);
    #1;
    for (int i = 0; i < 4; i++) if (grant[i]) g_log.push_back(i);
    if (dropped) drop_cnt++;
    if (sfx_active) act_cnt++;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      tick(4'd0, 1'b1);
      tick(4'd0, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'd0; frame_tick = 1'b0; bgm_enable = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (bgm_mute !== 1'b1 || sfx_active !== 1'b0 || grant !== 4'd0 || dropped !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: mute=%b active=%b grant=%b dropped=%b, want mute=1 active=0 grant=0000 dropped=0",
               bgm_mute, sfx_active, grant, dropped);
    end
    checks++;
    if (sfx_id !== 2'd0 || sfx_noise !== 1'b0 || sfx_period !== 9'd0 || envelope !== 5'd0) begin
      failures++;
      $display("FAIL reset_voice: id=%0d noise=%b period=%0d env=%0d, want all 0", sfx_id, sfx_noise, sfx_period, envelope);
    end
    rst_n = 1'b1;
    bgm_enable = 1'b1;
    tick(4'd0, 1'b0);
    tick(4'd0, 1'b1);
    checks++;
    if (bgm_mute !== 1'b0 || sfx_active !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: mute=%b active=%b, want mute=0 active=0", bgm_mute, sfx_active);
    end
  endtask

  task automatic test_single();
    tick(4'b0001, 1'b0);
    checks++;
    if (grant !== 4'b0001 || sfx_active !== 1'b0) begin
      failures++;
      $display("FAIL single_grant: grant=%b active=%b, want grant=0001 active=0", grant, sfx_active);
    end
    tick(4'd0, 1'b0);
    checks++;
    if (sfx_active !== 1'b1 || grant !== 4'd0 || sfx_id !== 2'd0 || bgm_mute !== 1'b1) begin
      failures++;
      $display("FAIL single_start: active=%b grant=%b id=%0d mute=%b, want 1 0000 0 1", sfx_active, grant, sfx_id, bgm_mute);
    end
    for (int f = 0; f < 16; f++) begin
      if (f > 0) tick(4'd0, 1'b1);
      tick(4'd0, 1'b0);
      checks++;
      if (sfx_period !== 9'(120 + 4 * f) || envelope !== 5'(31 - f) || sfx_noise !== 1'b0 || sfx_active !== 1'b1) begin
        failures++;
        $display("FAIL single_frame%0d: period=%0d env=%0d noise=%b active=%b, want %0d %0d 0 1",
                 f, sfx_period, envelope, sfx_noise, sfx_active, 120 + 4 * f, 31 - f);
      end
    end
    tick(4'd0, 1'b1);
    checks++;
    if (sfx_active !== 1'b0 || bgm_mute !== 1'b0 || sfx_period !== 9'd0 || envelope !== 5'd0) begin
      failures++;
      $display("FAIL single_gap: active=%b mute=%b period=%0d env=%0d, want 0 0 0 0", sfx_active, bgm_mute, sfx_period, envelope);
    end
    // A request arriving in the gap must wait for the gap frame to end.
    tick(4'b0001, 1'b0);
    tick(4'd0, 1'b0);
    checks++;
    if (grant !== 4'd0) begin
      failures++;
      $display("FAIL gap_hold: grant=%b, want 0000", grant);
    end
    tick(4'd0, 1'b1);
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL gap_release: grant=%b, want 0001", grant);
    end
    drain(20);
    checks++;
    if (sfx_active !== 1'b0 || m_id != -1) begin
      failures++;
      $display("FAIL single_drain: active=%b, want 0", sfx_active);
    end
  endtask

  task automatic test_preempt();
    int cnt = 0;
    g_log.delete();
    tick(4'b0010, 1'b0);
    tick(4'd0, 1'b0);
    for (int f = 0; f < 3; f++) begin
      tick(4'd0, 1'b1);
      tick(4'd0, 1'b0);
    end
    checks++;
    if (sfx_id !== 2'd1 || envelope !== 5'd28 || sfx_noise !== 1'b1 || sfx_period !== 9'd0) begin
      failures++;
      $display("FAIL preempt_pre: id=%0d env=%0d noise=%b period=%0d, want 1 28 1 0", sfx_id, envelope, sfx_noise, sfx_period);
    end
    tick(4'b1000, 1'b0);
    checks++;
    if (grant !== 4'b1000 || sfx_id !== 2'd1) begin
      failures++;
      $display("FAIL preempt_grant: grant=%b id=%0d, want 1000 1", grant, sfx_id);
    end
    // Frame tick coincides with the preemption; the restart must win.
    tick(4'b1000, 1'b1);
    checks++;
    if (sfx_id !== 2'd3 || envelope !== 5'd31 || sfx_noise !== 1'b1 || grant !== 4'd0 || sfx_active !== 1'b1) begin
      failures++;
      $display("FAIL preempt_restart: id=%0d env=%0d noise=%b grant=%b active=%b, want 3 31 1 0000 1",
               sfx_id, envelope, sfx_noise, grant, sfx_active);
    end
    tick(4'd0, 1'b0);
    g_log.delete();
    for (int f = 0; f < 40; f++) begin
      tick(4'd0, 1'b1);
      if (sfx_active) cnt++;
      tick(4'd0, 1'b0);
    end
    checks++;
    if (cnt != 31 || g_log.size() != 0) begin
      failures++;
      $display("FAIL preempt_len: active_ticks=%0d grants=%0d, want 31 0", cnt, g_log.size());
    end
  endtask

  task automatic test_wait_order();
    g_log.delete();
    tick(4'b1000, 1'b0);
    tick(4'd0, 1'b0);
    tick(4'b0001, 1'b0);
    tick(4'd0, 1'b0);
    tick(4'b0100, 1'b0);
    tick(4'd0, 1'b0);
    checks++;
    if (sfx_id !== 2'd3 || grant !== 4'd0) begin
      failures++;
      $display("FAIL wait_hold: id=%0d grant=%b, want 3 0000", sfx_id, grant);
    end
    drain(100);
    checks++;
    if (g_log.size() != 3 || g_log[0] != 3 || g_log[1] != 2 || g_log[2] != 0) begin
      failures++;
      $display("FAIL wait_order: count=%0d first=%0d second=%0d third=%0d, want 3 3 2 0", g_log.size(),
               g_log.size() > 0 ? g_log[0] : -1, g_log.size() > 1 ? g_log[1] : -1, g_log.size() > 2 ? g_log[2] : -1);
    end
  endtask

  task automatic test_dropped();
    g_log.delete();
    drop_cnt = 0;
    tick(4'b1000, 1'b0);
    tick(4'd0, 1'b0);
    tick(4'b0010, 1'b0);
    tick(4'd0, 1'b0);
    tick(4'b0010, 1'b0);
    tick(4'd0, 1'b0);
    checks++;
    if (drop_cnt != 1) begin
      failures++;
      $display("FAIL dropped_pulse: pulses=%0d, want 1", drop_cnt);
    end
    drain(100);
    checks++;
    if (g_log.size() != 2 || g_log[0] != 3 || g_log[1] != 1) begin
      failures++;
      $display("FAIL dropped_once: grants=%0d first=%0d second=%0d, want 2 3 1", g_log.size(),
               g_log.size() > 0 ? g_log[0] : -1, g_log.size() > 1 ? g_log[1] : -1);
    end
  endtask

  task automatic test_async_reset();
    tick(4'b0100, 1'b0);
    tick(4'd0, 1'b0);
    tick(4'd0, 1'b1);
    tick(4'b0001, 1'b0);
    checks++;
    if (sfx_active !== 1'b1 || sfx_id !== 2'd2 || envelope !== 5'd30 || sfx_period !== 9'd64) begin
      failures++;
      $display("FAIL areset_pre: active=%b id=%0d env=%0d period=%0d, want 1 2 30 64", sfx_active, sfx_id, envelope, sfx_period);
    end
    @(posedge clk);
    #3;
    bgm_enable = 1'b0;
    req = 4'd0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sfx_active !== 1'b0 || sfx_id !== 2'd0 || envelope !== 5'd0 || sfx_period !== 9'd0 ||
        sfx_noise !== 1'b0 || grant !== 4'd0 || bgm_mute !== 1'b1) begin
      failures++;
      $display("FAIL areset_async: active=%b id=%0d env=%0d period=%0d noise=%b grant=%b mute=%b, want 0 0 0 0 0 0000 1",
               sfx_active, sfx_id, envelope, sfx_period, sfx_noise, grant, bgm_mute);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bgm_enable = 1'b1;
    model_reset();
    g_log.delete();
    act_cnt = 0;
    drain(20);
    checks++;
    if (g_log.size() != 0 || act_cnt != 0) begin
      failures++;
      $display("FAIL areset_clean: grants=%0d active_cycles=%0d, want 0 0", g_log.size(), act_cnt);
    end
  endtask

  task automatic test_random();
    logic [3:0] r = 4'd0;
    logic       ft;
    int         bad = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 11) == 0) r[i] = ~r[i];
      ft = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 63) == 0) bgm_enable = ~bgm_enable;
      tick(r, ft);
      checks++;
      if (grant !== model_grant() || dropped !== m_drop || sfx_active !== (m_id >= 0) ||
          sfx_id !== 2'(m_id >= 0 ? m_id : 0) ||
          sfx_noise !== ((m_id >= 0) ? T_NOISE[m_id][0] : 1'b0) ||
          sfx_period !== 9'(model_period()) ||
          envelope !== 5'(m_id >= 0 ? 31 - m_frame : 0) ||
          bgm_mute !== ((m_id >= 0) | ~bgm_enable)) begin
        failures++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_c%0d: grant=%b drop=%b act=%b id=%0d noise=%b per=%0d env=%0d mute=%b, want grant=%b drop=%b act=%b id=%0d per=%0d env=%0d",
                   c, grant, dropped, sfx_active, sfx_id, sfx_noise, sfx_period, envelope, bgm_mute,
                   model_grant(), m_drop, m_id >= 0, m_id, model_period(), m_id >= 0 ? 31 - m_frame : 0);
      end
    end
  endtask

  initial begin
    drop_cnt = 0;
    act_cnt  = 0;
    test_reset();
    test_single();
    test_preempt();
    test_wait_order();
    test_dropped();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
